// File: rtl/fifo_vc_scheduler.sv
// ---------------------------------------------------------------------------
// fifo_vc_scheduler
//
// Controller/arbiter for the six-bit FIFO subsystem. It broadcasts the
// almost-empty/almost-full thresholds to every FIFO and arbitrates two
// virtual-channel input FIFOs (VC0, VC1). Each popped word is routed to one of
// four destination FIFOs chosen by its top two bits. The block also sequences
// the subsystem through RESET/INIT/IDLE/ACTIVE/ERROR.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants when both
// VCs are non-empty. Without it, VC0 has strict priority.
//
// Ports:
//   clk, reset_L            clock, asynchronous active-low reset
//   init                    request (re)configuration
//   umbral_empty_in/full_in thresholds loaded while in INIT
//   vc0_empty, vc1_empty    input FIFO empty flags
//   vc0_data, vc1_data      input FIFO registered data_out
//   dest_almost_full[3:0]   almost_full of destination FIFOs 0..3
//   fifo_error              OR of all FIFO error flags
//   vc0_pop, vc1_pop        pop strobes to the input FIFOs
//   dest_push[3:0]          one-hot push to the destination FIFOs
//   data_out                word driven to all destination FIFOs
//   buffer_empty/full       thresholds broadcast to all FIFOs
//   estado                  current state (RESET=0 .. ERROR=4)
//   idle_out/active_out/error_out  state decodes
// ---------------------------------------------------------------------------
module fifo_vc_scheduler #(
    parameter int                DATA_W           = 6,
    parameter int                ADDR_W           = 2,
    parameter logic [ADDR_W-1:0] DEF_UMBRAL_EMPTY = 2'd1,
    parameter logic [ADDR_W-1:0] DEF_UMBRAL_FULL  = 2'd2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic [ADDR_W-1:0] umbral_empty_in,
    input  logic [ADDR_W-1:0] umbral_full_in,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic [3:0]        dest_almost_full,
    input  logic              fifo_error,
    output logic              vc0_pop,
    output logic              vc1_pop,
    output logic [3:0]        dest_push,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] buffer_empty,
    output logic [ADDR_W-1:0] buffer_full,
    output logic [2:0]        estado,
    output logic              idle_out,
    output logic              active_out,
    output logic              error_out
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic              s1_valid_reg;   // pop issued last cycle, data appears on vcX_data now
    logic              s1_vc_reg;      // which VC that pop went to (1 = VC1)
    logic              s2_valid_reg;   // data_reg holds a word being pushed this cycle
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] buffer_empty_reg, buffer_full_reg;
    logic              pop_ok, any_ready, grant_vc1;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_grant_reg; // 1 = VC1 was granted last
`endif

    // Pops only in ACTIVE with no destination near full. A pop is also held
    // off while fifo_error is high, since the word would be discarded anyway.
    assign pop_ok    = (state_reg == ST_ACTIVE) && !fifo_error && (dest_almost_full == 4'b0000);
    assign any_ready = !vc0_empty || !vc1_empty;

    always_comb begin
        grant_vc1 = vc0_empty;
`ifdef ARB_ROUND_ROBIN_EN
        if (!vc0_empty && !vc1_empty)
            grant_vc1 = !last_grant_reg;
`endif
    end

    assign vc0_pop = pop_ok && any_ready && !grant_vc1;
    assign vc1_pop = pop_ok && any_ready && grant_vc1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RESET:  state_next = ST_INIT;
            ST_INIT: begin
                if (fifo_error)      state_next = ST_ERROR;
                else if (!init)      state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (fifo_error)      state_next = ST_ERROR;
                else if (init)       state_next = ST_INIT;
                else if (any_ready)  state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // The stage-2 word completes its push this cycle, so only the
                // stage-1 word can still hold the controller in ACTIVE.
                if (fifo_error)      state_next = ST_ERROR;
                else if (init)       state_next = ST_INIT;
                else if (vc0_empty && vc1_empty && !s1_valid_reg)
                                     state_next = ST_IDLE;
            end
            ST_ERROR: begin
                if (!fifo_error && init) state_next = ST_INIT;
            end
            default:                 state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg        <= ST_RESET;
            s1_valid_reg     <= 1'b0;
            s1_vc_reg        <= 1'b0;
            s2_valid_reg     <= 1'b0;
            data_reg         <= '0;
            buffer_empty_reg <= DEF_UMBRAL_EMPTY;
            buffer_full_reg  <= DEF_UMBRAL_FULL;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_reg   <= 1'b1;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_INIT) begin
                buffer_empty_reg <= umbral_empty_in;
                buffer_full_reg  <= umbral_full_in;
            end
            s1_valid_reg <= vc0_pop || vc1_pop;
            s1_vc_reg    <= vc1_pop;
            // Entering ERROR drops whatever is still in flight.
            s2_valid_reg <= (state_next == ST_ERROR) ? 1'b0 : s1_valid_reg;
            if (s1_valid_reg)
                data_reg <= s1_vc_reg ? vc1_data : vc0_data;
`ifdef ARB_ROUND_ROBIN_EN
            if (vc0_pop || vc1_pop)
                last_grant_reg <= vc1_pop;
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_push
            assign dest_push[gi] = s2_valid_reg && (data_reg[DATA_W-1 -: 2] == 2'(gi));
        end
    endgenerate

    assign data_out     = data_reg;
    assign buffer_empty = buffer_empty_reg;
    assign buffer_full  = buffer_full_reg;
    assign estado       = state_reg;
    assign idle_out     = (state_reg == ST_IDLE);
    assign active_out   = (state_reg == ST_ACTIVE);
    assign error_out    = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_fifo_vc_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fifo_vc_scheduler
//
// Directed sequence of phases with randomized word contents and traffic. The
// input FIFOs are modelled as queues. The reference model tracks the abstract
// state, the thresholds, and a list of in-flight words tagged with the cycle
// their push is due (pop cycle + 2). Outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_fifo_vc_scheduler;

    localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;

    logic       clk = 1'b0;
    logic       reset_L, init, vc0_empty, vc1_empty, fifo_error;
    logic [1:0] umbral_empty_in, umbral_full_in;
    logic [5:0] vc0_data, vc1_data;
    logic [3:0] dest_almost_full;
    logic       vc0_pop, vc1_pop, idle_out, active_out, error_out;
    logic [3:0] dest_push;
    logic [5:0] data_out;
    logic [1:0] buffer_empty, buffer_full;
    logic [2:0] estado;

    fifo_vc_scheduler dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_empty_in(umbral_empty_in), .umbral_full_in(umbral_full_in),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .dest_almost_full(dest_almost_full), .fifo_error(fifo_error),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop), .dest_push(dest_push),
        .data_out(data_out), .buffer_empty(buffer_empty), .buffer_full(buffer_full),
        .estado(estado), .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] w;
        int         due;
    } fl_t;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    fl_t        infl[$];
    int         m_state;
    logic [1:0] m_be, m_bf;
    bit         m_last1;
    int         cyc;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic refresh_flags();
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
    endtask

    task automatic model_reset();
        m_state = S_RESET;
        m_be    = 2'd1;
        m_bf    = 2'd2;
        m_last1 = 1'b1;
        infl.delete();
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the
    // rising edge, then update the input FIFO outputs just after it.
    task automatic step();
        bit         e0, e1, p0, p1, push, allow;
        logic [5:0] w, nd0, nd1;
        logic [3:0] exp_push;
        int         nxt;
        @(negedge clk);
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
        p0 = 0; p1 = 0;
        allow = (m_state == S_ACTIVE) && !fifo_error && (dest_almost_full == 4'b0);
        if (allow) begin
            if (!e0 && !e1) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (m_last1) p0 = 1; else p1 = 1;
`else
                p0 = 1;
`endif
            end else if (!e0) p0 = 1;
            else if (!e1)     p1 = 1;
        end
        push     = (infl.size() > 0) && (infl[0].due == cyc);
        w        = push ? infl[0].w : 6'd0;
        exp_push = push ? (4'b0001 << w[5:4]) : 4'b0000;
        check("estado", 32'(estado), 32'(m_state));
        check("vc0_pop", 32'(vc0_pop), 32'(p0));
        check("vc1_pop", 32'(vc1_pop), 32'(p1));
        check("dest_push", 32'(dest_push), 32'(exp_push));
        if (push) begin
            check("data_out", 32'(data_out), 32'(w));
            $display("push cycle=%0d dest=%0d data=%h", cyc, w[5:4], w);
        end
        if (m_state == S_RESET) check("data_out_rst", 32'(data_out), 32'd0);
        check("buffer_empty", 32'(buffer_empty), 32'(m_be));
        check("buffer_full", 32'(buffer_full), 32'(m_bf));
        check("idle_out", 32'(idle_out), 32'(m_state == S_IDLE));
        check("active_out", 32'(active_out), 32'(m_state == S_ACTIVE));
        check("error_out", 32'(error_out), 32'(m_state == S_ERROR));

        @(posedge clk);
        if (push) void'(infl.pop_front());
        if (!reset_L) begin
            model_reset();
            cyc++;
            #1;
            return;
        end
        nxt = m_state;
        case (m_state)
            S_RESET:  nxt = S_INIT;
            S_INIT:   nxt = fifo_error ? S_ERROR : (!init ? S_IDLE : S_INIT);
            S_IDLE:   nxt = fifo_error ? S_ERROR : init ? S_INIT : (!e0 || !e1) ? S_ACTIVE : S_IDLE;
            S_ACTIVE: begin
                if (fifo_error) nxt = S_ERROR;
                else if (init)  nxt = S_INIT;
                else begin
                    bit later = 0;
                    foreach (infl[k]) if (infl[k].due > cyc) later = 1;
                    if (e0 && e1 && !later && !p0 && !p1) nxt = S_IDLE;
                end
            end
            S_ERROR:  nxt = (!fifo_error && init) ? S_INIT : S_ERROR;
            default:  nxt = S_RESET;
        endcase
        if (m_state == S_INIT) begin
            m_be = umbral_empty_in;
            m_bf = umbral_full_in;
        end
        nd0 = vc0_data;
        nd1 = vc1_data;
        if (p0) begin
            fl_t e;
            e.w = q0.pop_front(); e.due = cyc + 2;
            infl.push_back(e);
            nd0 = e.w;
            m_last1 = 1'b0;
        end
        if (p1) begin
            fl_t e;
            e.w = q1.pop_front(); e.due = cyc + 2;
            infl.push_back(e);
            nd1 = e.w;
            m_last1 = 1'b1;
        end
        if (nxt == S_ERROR) infl.delete();
        m_state = nxt;
        cyc++;
        #1;
        vc0_data = nd0;
        vc1_data = nd1;
        refresh_flags();
    endtask

    task automatic load(input int vc, input int n);
        for (int i = 0; i < n; i++) begin
            if (vc == 0) q0.push_back(6'($urandom));
            else         q1.push_back(6'($urandom));
        end
        refresh_flags();
    endtask

    initial begin
        reset_L = 0; init = 0; fifo_error = 0; dest_almost_full = 4'b0;
        umbral_empty_in = 2'd0; umbral_full_in = 2'd0;
        vc0_data = 6'd0; vc1_data = 6'd0;
        cyc = 0;
        model_reset();
        refresh_flags();
        repeat (2) step();

        // Release reset, configure thresholds 1/3 over two INIT cycles.
        reset_L = 1;
        step();
        init = 1; umbral_empty_in = 2'd1; umbral_full_in = 2'd3;
        repeat (2) step();
        init = 0;
        repeat (2) step();

        // Single word 01_0101 on VC0 -> destination 1.
        q0.push_back(6'b01_0101);
        refresh_flags();
        repeat (6) step();

        // Three words per VC, destinations 0..3.
        q0.push_back({2'd0, 4'($urandom)});
        q0.push_back({2'd1, 4'($urandom)});
        q0.push_back({2'd2, 4'($urandom)});
        q1.push_back({2'd3, 4'($urandom)});
        q1.push_back({2'd0, 4'($urandom)});
        q1.push_back({2'd1, 4'($urandom)});
        refresh_flags();
        repeat (12) step();

        // Backpressure raised mid-burst, then released.
        load(0, 8); load(1, 8);
        repeat (4) step();
        dest_almost_full = 4'b1000;
        repeat (4) step();
        dest_almost_full = 4'b0000;
        repeat (24) step();

        // Random traffic and random backpressure.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) load($urandom_range(0, 1), $urandom_range(1, 3));
            dest_almost_full = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            step();
        end
        dest_almost_full = 4'b0000;
        repeat (40) step();

        // Error with words in flight, then reconfigure.
        load(0, 4);
        repeat (4) step();
        fifo_error = 1;
        step();
        fifo_error = 0;
        repeat (3) step();
        umbral_empty_in = 2'($urandom); umbral_full_in = 2'($urandom);
        init = 1;
        repeat (2) step();
        init = 0;
        repeat (15) step();

        // init asserted during a transfer; in-flight pushes still land.
        load(0, 4); load(1, 4);
        repeat (3) step();
        init = 1;
        step();
        init = 0;
        repeat (14) step();

        // Asynchronous reset mid-transfer.
        load(0, 5);
        repeat (4) step();
        #1 reset_L = 0;
        #1;
        check("async_estado", 32'(estado), 32'd0);
        check("async_pops", 32'({vc0_pop, vc1_pop}), 32'd0);
        check("async_push", 32'(dest_push), 32'd0);
        check("async_data", 32'(data_out), 32'd0);
        check("async_thr", 32'({buffer_empty, buffer_full}), 32'({2'd1, 2'd2}));
        check("async_status", 32'({idle_out, active_out, error_out}), 32'd0);
        model_reset();
        q0.delete(); q1.delete();
        vc0_data = 6'd0; vc1_data = 6'd0;
        refresh_flags();
        step();
        reset_L = 1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_vc_scheduler.md
Name: fifo_vc_scheduler

Overview:
- Controller and arbiter for the six-bit FIFO datapath.
- Configures almost-empty/almost-full thresholds of all attached FIFOs.
- Arbitrates two virtual-channel input FIFOs (VC0, VC1) and routes each popped word to one of four destination FIFOs selected by data bits [DATA_W-1:DATA_W-2].
- Sequences the whole FIFO subsystem through a RESET/INIT/IDLE/ACTIVE/ERROR state machine.

Parameters:
- DATA_W, 6, word width; top two bits are the destination index.
- ADDR_W, 2, FIFO address width; also the threshold width.
- DEF_UMBRAL_EMPTY, 2'd1, almost-empty threshold driven after reset.
- DEF_UMBRAL_FULL, 2'd2, almost-full threshold driven after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- init  in  1  request (re)configuration.
- umbral_empty_in  in  ADDR_W  almost-empty threshold to load in INIT.
- umbral_full_in  in  ADDR_W  almost-full threshold to load in INIT.
- vc0_empty, vc1_empty  in  1 each  input FIFO empty flags.
- vc0_data, vc1_data  in  DATA_W each  input FIFO registered data_out.
- dest_almost_full  in  4  almost_full of destination FIFOs 0..3.
- fifo_error  in  1  OR of all FIFO error flags.
- vc0_pop, vc1_pop  out  1 each  pop strobes to input FIFOs.
- dest_push  out  4  one-hot push to destination FIFOs.
- data_out  out  DATA_W  word driven to all destination FIFOs.
- buffer_empty, buffer_full  out  ADDR_W each  thresholds broadcast to all FIFOs.
- estado  out  3  current state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- idle_out, active_out, error_out  out  1 each  state decodes.

Behaviour:
- Reset while reset_L=0, asynchronous, at any time including mid-transfer:
  - estado=RESET.
  - All pops, pushes, data_out, in-flight valid bits and status outputs = 0.
  - buffer_empty=DEF_UMBRAL_EMPTY, buffer_full=DEF_UMBRAL_FULL.
- State transitions:
  - RESET -> INIT on the first edge with reset_L=1.
  - INIT: every edge, buffer_empty<=umbral_empty_in and buffer_full<=umbral_full_in. Go to IDLE on the first edge with init=0. No pops.
  - IDLE -> ACTIVE when vc0_empty=0 or vc1_empty=0.
  - ACTIVE -> IDLE when both VCs are empty and both pipeline stages are invalid.
  - From IDLE or ACTIVE, init=1 -> INIT. In-flight words still complete their push.
  - From any state except RESET, fifo_error=1 -> ERROR. This has priority over init.
  - ERROR: pops and pushes forced to 0; in-flight words are discarded. Exit only via init=1 -> INIT, or reset.
- Pop rule, evaluated combinationally in ACTIVE:
  - Pop is allowed when dest_almost_full==4'b0000.
  - Grant VC0 if vc0_empty=0; else grant VC1 if vc1_empty=0.
  - At most one pop per cycle. Back-to-back pops are allowed.
  - Empty flags update on the same edge that consumes a pop.
- Latency:
  - Pop in cycle N; vcX_data valid in N+1; the controller registers it at the end of N+1.
  - In N+2: data_out = word, dest_push[word[DATA_W-1:DATA_W-2]]=1, single cycle, one-hot.
  - Fixed pop->push latency of 2 cycles; throughput 1 word/cycle.
- Backpressure: any dest_almost_full bit stalls new pops. Up to 2 in-flight words still land. umbral_full must leave at least 2 free entries; this is the configuration contract, not checked by the block.
- Simultaneity: a push in a cycle where almost_full rises is not cancelled. init and a pending push in the same cycle: the push completes in INIT.
- Ordering: output order equals pop order. No reordering within or across VCs.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both VCs are non-empty, grants alternate using a last-grant register (reset to VC1, so VC0 wins first). With a single non-empty VC, that VC is granted every cycle.
- Undefined: strict VC0 priority as specified above; VC1 can starve.

Test Plan:
- Reset then init=1 for 2 cycles with umbral_empty_in=1, umbral_full_in=3, then init=0 -> estado 0->1->2; buffer_empty=1, buffer_full=3; no pops.
- VC0 holds 6'b01_0101, VC1 empty, in IDLE -> ACTIVE; vc0_pop at N; data_out=6'h15 with dest_push=4'b0010 at N+2; back to IDLE at N+3.
- Both VCs hold 3 words each, destinations 0..3 -> all VC0 words pushed before any VC1 word (with ARB_ROUND_ROBIN_EN: pushes alternate VC0, VC1, VC0, ...). Throughput 1/cycle, no gaps.
- dest_almost_full=4'b1000 raised mid-burst -> pops stop the same cycle; exactly the 2 in-flight words are pushed. Pops resume the cycle after the flag clears.
- fifo_error=1 during ACTIVE with words in flight -> ERROR next edge; no further dest_push; error_out=1. Then init=1 -> INIT and thresholds reloaded.
- reset_L=0 asynchronously mid-transfer -> outputs zero immediately; thresholds return to 1/2; after release, estado goes to INIT.
